fp_regfile_sb: RTL and testbench

Parametrised floating-point register file with multiple read ports, two write ports, NaN-boxing of single-precision writes, and a load scoreboard that tracks outstanding FP loads. It sits between FP decode/issue, the FPU writeback stage and the load/integer-move return path. It replaces the single-write, combinationally-loaded FP register array.

---
 rtl/fp_regfile_pkg.sv | 26 ++
 rtl/fp_regfile_sb_fp_ld_scoreboard.sv | 85 ++++++++
 rtl/fp_regfile_sb.sv | 113 +++++++++++
 tb/tb_fp_regfile_sb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_regfile_pkg.sv
// Shared types and helpers for the FP register file: write-port bundle and
// NaN-boxing of single-precision values into wider registers.
package fp_regfile_pkg;

    localparam int FLEN_MAX   = 64;
    localparam int ADDR_W_MAX = 8;
    localparam logic [FLEN_MAX-1:0] NAN_BOX_MASK = 64'hFFFF_FFFF_0000_0000;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_MAX-1:0] addr;
        logic [FLEN_MAX-1:0]   data;
        logic                  single;
    } fp_wr_port_t;

    // Singles living in a wider register get their upper half forced to ones.
    function automatic logic [FLEN_MAX-1:0] nan_box(input fp_wr_port_t p, input int flen);
        logic [FLEN_MAX-1:0] r;
        r = p.data;
        if (flen > 32 && p.single) begin
            r = r | NAN_BOX_MASK;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_regfile_sb_fp_ld_scoreboard.sv
// Outstanding FP load tracker: busy bits, load count, issue-ready, decode
// hazard and the registered protocol-error pulse.
module fp_ld_scoreboard #(
    parameter int NREGS  = 32,
    parameter int NRD    = 3,
    parameter int MAX_LD = 4,
    parameter int AW     = $clog2(NREGS),
    parameter int CW     = $clog2(MAX_LD) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic [AW-1:0]     issue_rd_i,
    input  logic              fpu_we_i,
    input  logic [AW-1:0]     fpu_waddr_i,
    input  logic              ret_valid_i,
    input  logic [AW-1:0]     ret_rd_i,
    input  logic              conflict_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    input  logic [NRD-1:0]    rd_en_i,
    output logic              ready_o,
    output logic              hazard_o,
    output logic [NREGS-1:0]  busy_o,
    output logic [CW-1:0]     count_o,
    output logic              err_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_d;
    logic             issue_acc, ret_ok, same_reg;

    assign ready_o = (count_q < CW'(MAX_LD)) && !busy_q[issue_rd_i]
                     && !(fpu_we_i && (fpu_waddr_i == issue_rd_i));

    // A register whose load returns this cycle no longer blocks decode.
    always_comb begin
        hazard_o = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_en_i[p] && busy_q[rd_addr_i[p*AW +: AW]]
                && !(ret_valid_i && (ret_rd_i == rd_addr_i[p*AW +: AW]))) begin
                hazard_o = 1'b1;
            end
        end
    end

    always_comb begin
        issue_acc = issue_valid_i && ready_o;
        ret_ok    = ret_valid_i && busy_q[ret_rd_i] && (count_q != '0);
        same_reg  = issue_acc && ret_valid_i && (issue_rd_i == ret_rd_i);
        busy_d    = busy_q;
        count_d   = count_q;
        if (ret_valid_i) begin
            busy_d[ret_rd_i] = 1'b0;
        end
        if (issue_acc) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        if (!same_reg) begin
            if (issue_acc) begin
                count_d = count_d + CW'(1);
            end
            if (ret_ok) begin
                count_d = count_d - CW'(1);
            end
        end
        err_d = conflict_i || (ret_valid_i && !same_reg && !ret_ok);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q  <= '0;
            count_q <= '0;
            err_o   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_o   <= err_d;
        end
    end

    assign busy_o  = busy_q;
    assign count_o = count_q;

endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file with two write ports (port 1 wins), NaN-boxing, bypassed
// combinational reads and an outstanding-load scoreboard.
module fp_regfile_sb import fp_regfile_pkg::*; #(
    parameter int FLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 3,
    parameter int MAX_LD = 4,
    parameter int AW     = $clog2(NREGS),
    parameter int CW     = $clog2(MAX_LD) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    input  logic [NRD-1:0]      rd_en_i,
    output logic [NRD*FLEN-1:0] rd_data_o,
    input  logic                fpu_we_i,
    input  logic [AW-1:0]       fpu_waddr_i,
    input  logic [FLEN-1:0]     fpu_wdata_i,
    input  logic                fpu_single_i,
    input  logic                mem_we_i,
    input  logic                mem_is_ld_i,
    input  logic [AW-1:0]       mem_waddr_i,
    input  logic [FLEN-1:0]     mem_wdata_i,
    input  logic                mem_single_i,
    input  logic                ld_issue_valid_i,
    input  logic [AW-1:0]       ld_issue_rd_i,
    output logic                ld_issue_ready_o,
    output logic                hazard_o,
    output logic [NREGS-1:0]    busy_o,
    output logic [CW-1:0]       ld_count_o,
    output logic                err_o
);

    fp_wr_port_t         wp0, wp1;
    logic [FLEN_MAX-1:0] box0_full, box1_full;
    logic [FLEN-1:0]     box0, box1;
    logic [FLEN-1:0]     regs_q [NREGS];
    logic                conflict;

    always_comb begin
        wp0        = '0;
        wp0.we     = fpu_we_i;
        wp0.addr   = ADDR_W_MAX'(fpu_waddr_i);
        wp0.data   = FLEN_MAX'(fpu_wdata_i);
        wp0.single = fpu_single_i;
        wp1        = '0;
        wp1.we     = mem_we_i;
        wp1.addr   = ADDR_W_MAX'(mem_waddr_i);
        wp1.data   = FLEN_MAX'(mem_wdata_i);
        wp1.single = mem_single_i;
    end

    assign box0_full = nan_box(wp0, FLEN);
    assign box1_full = nan_box(wp1, FLEN);
    assign box0      = box0_full[FLEN-1:0];
    assign box1      = box1_full[FLEN-1:0];
    assign conflict  = wp0.we && wp1.we && (wp0.addr == wp1.addr);

    // Port 1 is written last so it overrides port 0 on an address clash.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wp0.we) begin
                regs_q[fpu_waddr_i] <= box0;
            end
            if (wp1.we) begin
                regs_q[mem_waddr_i] <= box1;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data_o[p*FLEN +: FLEN] = regs_q[rd_addr_i[p*AW +: AW]];
            if (fpu_we_i && (fpu_waddr_i == rd_addr_i[p*AW +: AW])) begin
                rd_data_o[p*FLEN +: FLEN] = box0;
            end
            if (mem_we_i && (mem_waddr_i == rd_addr_i[p*AW +: AW])) begin
                rd_data_o[p*FLEN +: FLEN] = box1;
            end
        end
    end

    fp_ld_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .MAX_LD (MAX_LD),
        .AW     (AW),
        .CW     (CW)
    ) u_sb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (ld_issue_valid_i),
        .issue_rd_i    (ld_issue_rd_i),
        .fpu_we_i      (fpu_we_i),
        .fpu_waddr_i   (fpu_waddr_i),
        .ret_valid_i   (mem_we_i && mem_is_ld_i),
        .ret_rd_i      (mem_waddr_i),
        .conflict_i    (conflict),
        .rd_addr_i     (rd_addr_i),
        .rd_en_i       (rd_en_i),
        .ready_o       (ld_issue_ready_o),
        .hazard_o      (hazard_o),
        .busy_o        (busy_o),
        .count_o       (ld_count_o),
        .err_o         (err_o)
    );

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Randomised and directed bench for fp_regfile_sb (FLEN=64, MAX_LD=2) against
// a behavioural register-file/scoreboard model.
module tb_fp_regfile_sb;

    localparam int FLEN   = 64;
    localparam int NREGS  = 32;
    localparam int NRD    = 3;
    localparam int MAX_LD = 2;
    localparam int AW     = 5;
    localparam int CW     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_en;
    logic [NRD*FLEN-1:0] rd_data;
    logic                fpu_we, fpu_single, mem_we, mem_is_ld, mem_single;
    logic [AW-1:0]       fpu_waddr, mem_waddr, ld_issue_rd;
    logic [FLEN-1:0]     fpu_wdata, mem_wdata;
    logic                ld_issue_valid, ld_issue_ready, hazard, err;
    logic [NREGS-1:0]    busy;
    logic [CW-1:0]       ld_count;
    logic [AW-1:0]       ra [NRD];

    logic [FLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    int              m_count;
    bit              m_err;
    int              n_cmp = 0;
    int              n_fail = 0;

    assign rd_addr = {ra[2], ra[1], ra[0]};

    always #5 clk = ~clk;

    fp_regfile_sb #(.FLEN(FLEN), .NREGS(NREGS), .NRD(NRD), .MAX_LD(MAX_LD)) dut (
        .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_en_i(rd_en), .rd_data_o(rd_data),
        .fpu_we_i(fpu_we), .fpu_waddr_i(fpu_waddr), .fpu_wdata_i(fpu_wdata), .fpu_single_i(fpu_single),
        .mem_we_i(mem_we), .mem_is_ld_i(mem_is_ld), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .mem_single_i(mem_single), .ld_issue_valid_i(ld_issue_valid), .ld_issue_rd_i(ld_issue_rd),
        .ld_issue_ready_o(ld_issue_ready), .hazard_o(hazard), .busy_o(busy), .ld_count_o(ld_count),
        .err_o(err)
    );

    function automatic logic [FLEN-1:0] box(input logic [FLEN-1:0] d, input logic single);
        return single ? {32'hFFFF_FFFF, d[31:0]} : d;
    endfunction

    function automatic logic [FLEN-1:0] exp_read(input int p);
        logic [FLEN-1:0] v;
        v = m_regs[ra[p]];
        if (fpu_we && fpu_waddr == ra[p]) v = box(fpu_wdata, fpu_single);
        if (mem_we && mem_waddr == ra[p]) v = box(mem_wdata, mem_single);
        return v;
    endfunction

    function automatic bit exp_ready();
        return (m_count < MAX_LD) && !m_busy[ld_issue_rd] && !(fpu_we && fpu_waddr == ld_issue_rd);
    endfunction

    function automatic bit exp_hazard();
        bit h = 0;
        for (int p = 0; p < NRD; p++)
            if (rd_en[p] && m_busy[ra[p]] && !(mem_we && mem_is_ld && mem_waddr == ra[p])) h = 1;
        return h;
    endfunction

    function automatic logic [NREGS-1:0] exp_busy();
        logic [NREGS-1:0] b;
        for (int i = 0; i < NREGS; i++) b[i] = m_busy[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
        m_count = 0;
        m_err   = 0;
    endtask

    task automatic model_step();
        bit acc, ret, legit, same;
        acc   = ld_issue_valid && exp_ready();
        ret   = mem_we && mem_is_ld;
        legit = ret && m_busy[mem_waddr] && m_count > 0;
        same  = acc && ret && ld_issue_rd == mem_waddr;
        m_err = (fpu_we && mem_we && fpu_waddr == mem_waddr) || (ret && !same && !legit);
        if (fpu_we) m_regs[fpu_waddr] = box(fpu_wdata, fpu_single);
        if (mem_we) m_regs[mem_waddr] = box(mem_wdata, mem_single);
        if (ret) m_busy[mem_waddr] = 0;
        if (acc) m_busy[ld_issue_rd] = 1;
        if (!same) m_count = m_count + int'(acc) - int'(legit);
    endtask

    task automatic idle();
        fpu_we = 0; fpu_waddr = '0; fpu_wdata = '0; fpu_single = 0;
        mem_we = 0; mem_is_ld = 0; mem_waddr = '0; mem_wdata = '0; mem_single = 0;
        ld_issue_valid = 0; ld_issue_rd = '0; rd_en = '0;
        for (int p = 0; p < NRD; p++) ra[p] = '0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        model_reset();
        ra[0] = 5;
        #3;
        n_cmp++; if (busy !== '0) begin n_fail++; $display("[TB] FAIL reset_busy: got %h want 0", busy); end
        n_cmp++; if (ld_count !== '0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", ld_count); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (ld_issue_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", ld_issue_ready); end
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hazard: got %b want 0", hazard); end
        n_cmp++; if (rd_data[63:0] !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_read_x5: got %h want 0", rd_data[63:0]); end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_nan_box();
        idle();
        fpu_we = 1; fpu_waddr = 3; fpu_single = 1;
        fpu_wdata = {$urandom(), 32'h3F80_0000};
        ra[0] = 3;
        #1;
        n_cmp++; if (rd_data[63:0] !== 64'hFFFF_FFFF_3F80_0000) begin n_fail++; $display("[TB] FAIL nanbox_bypass: got %h want ffffffff3f800000", rd_data[63:0]); end
        cycle();
        idle(); ra[1] = 3;
        #1;
        n_cmp++; if (rd_data[127:64] !== 64'hFFFF_FFFF_3F80_0000) begin n_fail++; $display("[TB] FAIL nanbox_stored: got %h want ffffffff3f800000", rd_data[127:64]); end
    endtask

    task automatic test_load_lifecycle();
        logic [FLEN-1:0] d;
        idle();
        ld_issue_valid = 1; ld_issue_rd = 1;
        #1;
        n_cmp++; if (ld_issue_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ld_ready_f1: got %b want 1", ld_issue_ready); end
        cycle();
        ld_issue_rd = 2;
        cycle();
        ld_issue_rd = 10; ra[0] = 1; rd_en = 3'b001;
        #1;
        n_cmp++; if (ld_count !== 2'd2) begin n_fail++; $display("[TB] FAIL ld_count_full: got %0d want 2", ld_count); end
        n_cmp++; if (ld_issue_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ld_ready_full: got %b want 0", ld_issue_ready); end
        n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("[TB] FAIL ld_hazard_busy: got %b want 1", hazard); end
        cycle();
        d = {$urandom(), $urandom()};
        ld_issue_valid = 0; mem_we = 1; mem_is_ld = 1; mem_waddr = 1; mem_wdata = d;
        #1;
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("[TB] FAIL ld_hazard_return: got %b want 0", hazard); end
        n_cmp++; if (rd_data[63:0] !== d) begin n_fail++; $display("[TB] FAIL ld_return_bypass: got %h want %h", rd_data[63:0], d); end
        cycle();
        n_cmp++; if (ld_count !== 2'd1) begin n_fail++; $display("[TB] FAIL ld_count_after_ret: got %0d want 1", ld_count); end
        n_cmp++; if (busy[2:1] !== 2'b10) begin n_fail++; $display("[TB] FAIL ld_busy_after_ret: got %b want 10", busy[2:1]); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL ld_err_legit: got %b want 0", err); end
        mem_waddr = 2;
        cycle();
        idle();
        n_cmp++; if (ld_count !== 2'd0) begin n_fail++; $display("[TB] FAIL ld_count_drained: got %0d want 0", ld_count); end
    endtask

    task automatic test_waw_block();
        idle();
        ld_issue_valid = 1; ld_issue_rd = 4;
        cycle();
        #1;
        n_cmp++; if (ld_issue_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL waw_ready: got %b want 0", ld_issue_ready); end
        cycle();
        n_cmp++; if (busy !== 32'h10 || ld_count !== 2'd1) begin n_fail++; $display("[TB] FAIL waw_state: got busy %h cnt %0d want 00000010 cnt 1", busy, ld_count); end
        ld_issue_valid = 0; mem_we = 1; mem_is_ld = 1; mem_waddr = 4; mem_wdata = 64'h4;
        cycle();
        idle(); ld_issue_valid = 1; ld_issue_rd = 4;
        #1;
        n_cmp++; if (ld_issue_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL waw_reissue_ready: got %b want 1", ld_issue_ready); end
        cycle();
        idle(); mem_we = 1; mem_is_ld = 1; mem_waddr = 4;
        cycle();
        idle();
    endtask

    task automatic test_conflict();
        idle();
        fpu_we = 1; fpu_waddr = 7; fpu_wdata = 64'h11;
        mem_we = 1; mem_waddr = 7; mem_wdata = 64'h22;
        ra[2] = 7;
        #1;
        n_cmp++; if (rd_data[191:128] !== 64'h22) begin n_fail++; $display("[TB] FAIL conflict_bypass: got %h want 22", rd_data[191:128]); end
        cycle();
        idle(); ra[0] = 7;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL conflict_err: got %b want 1", err); end
        n_cmp++; if (rd_data[63:0] !== 64'h22) begin n_fail++; $display("[TB] FAIL conflict_winner: got %h want 22", rd_data[63:0]); end
        cycle();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL conflict_err_pulse: got %b want 0", err); end
    endtask

    task automatic test_spurious();
        logic [FLEN-1:0] d;
        idle();
        d = {$urandom(), $urandom()};
        mem_we = 1; mem_is_ld = 1; mem_waddr = 9; mem_wdata = d;
        cycle();
        idle(); ra[1] = 9;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL spurious_err: got %b want 1", err); end
        n_cmp++; if (ld_count !== 2'd0) begin n_fail++; $display("[TB] FAIL spurious_count: got %0d want 0", ld_count); end
        n_cmp++; if (rd_data[127:64] !== d) begin n_fail++; $display("[TB] FAIL spurious_data: got %h want %h", rd_data[127:64], d); end
        cycle();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL spurious_err_pulse: got %b want 0", err); end
    endtask

    task automatic test_random();
        int start;
        for (int c = 0; c < 400; c++) begin
            idle();
            fpu_we = 1'($urandom_range(0, 1)); fpu_waddr = 5'($urandom());
            fpu_wdata = {$urandom(), $urandom()}; fpu_single = 1'($urandom_range(0, 1));
            ld_issue_valid = ($urandom_range(0, 2) == 0); ld_issue_rd = 5'($urandom());
            if (m_count > 0 && $urandom_range(0, 1) == 1) begin
                start = $urandom_range(0, NREGS - 1);
                for (int k = 0; k < NREGS; k++)
                    if (!mem_we && m_busy[(start + k) % NREGS]) begin
                        mem_we = 1; mem_is_ld = 1; mem_waddr = 5'((start + k) % NREGS);
                    end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_we = 1; mem_is_ld = ($urandom_range(0, 3) == 0); mem_waddr = 5'($urandom());
            end
            mem_wdata = {$urandom(), $urandom()}; mem_single = 1'($urandom_range(0, 1));
            if (ld_issue_valid && mem_we && mem_is_ld && mem_waddr == ld_issue_rd) ld_issue_valid = 0;
            for (int p = 0; p < NRD; p++) ra[p] = 5'($urandom());
            rd_en = 3'($urandom());
            #1;
            n_cmp++; if (ld_issue_ready !== exp_ready()) begin n_fail++; $display("[TB] FAIL rnd_ready c%0d: got %b want %b", c, ld_issue_ready, exp_ready()); end
            n_cmp++; if (hazard !== exp_hazard()) begin n_fail++; $display("[TB] FAIL rnd_hazard c%0d: got %b want %b", c, hazard, exp_hazard()); end
            for (int p = 0; p < NRD; p++) begin
                n_cmp++;
                if (rd_data[p*FLEN +: FLEN] !== exp_read(p)) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_read c%0d p%0d: got %h want %h", c, p, rd_data[p*FLEN +: FLEN], exp_read(p));
                end
            end
            cycle();
            n_cmp++; if (err !== m_err) begin n_fail++; $display("[TB] FAIL rnd_err c%0d: got %b want %b", c, err, m_err); end
            n_cmp++; if (busy !== exp_busy()) begin n_fail++; $display("[TB] FAIL rnd_busy c%0d: got %h want %h", c, busy, exp_busy()); end
            n_cmp++; if (ld_count !== 2'(m_count)) begin n_fail++; $display("[TB] FAIL rnd_count c%0d: got %0d want %0d", c, ld_count, m_count); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        fpu_we = 1; fpu_waddr = 5; fpu_wdata = 64'hDEAD_BEEF_0000_0005;
        ld_issue_valid = 1; ld_issue_rd = 6;
        cycle();
        idle();
        fpu_we = 1; fpu_waddr = 12; fpu_wdata = 64'h1234;
        ld_issue_valid = 1; ld_issue_rd = 8;
        ra[0] = 5; ra[1] = 6; rd_en = 3'b010;
        rst = 1;
        #1;
        model_reset();
        n_cmp++; if (busy !== '0 || ld_count !== '0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_state: got busy %h cnt %0d err %b want 0/0/0", busy, ld_count, err); end
        n_cmp++; if (ld_issue_ready !== 1'b1 || hazard !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ctl: got ready %b hazard %b want 1/0", ld_issue_ready, hazard); end
        n_cmp++; if (rd_data[63:0] !== 64'h0) begin n_fail++; $display("[TB] FAIL midrst_read_x5: got %h want 0", rd_data[63:0]); end
        @(posedge clk); #1;
        rst = 0;
        idle();
        mem_we = 1; mem_is_ld = 1; mem_waddr = 6; mem_wdata = 64'h66;
        cycle();
        idle();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_late_return_err: got %b want 1", err); end
        n_cmp++; if (ld_count !== 2'd0) begin n_fail++; $display("[TB] FAIL midrst_late_return_count: got %0d want 0", ld_count); end
    endtask

    initial begin
        test_reset();
        test_nan_box();
        test_load_lifecycle();
        test_waw_block();
        test_conflict();
        test_spurious();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
